bit_morph_3x3: RTL and testbench

BIT_MORPH_3X3 -- requirements
Module: bit_morph_3x3

---
 rtl/bit_morph_3x3_pkg.sv | 22 ++
 rtl/bit_morph_3x3_line_buffer.sv | 29 ++
 rtl/bit_morph_3x3.sv | 177 +++++++++++++++++
 tb/tb_bit_morph_3x3.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bit_morph_3x3_pkg.sv
// Shared constants for the 3x3 binary morphology block: pipeline depth,
// operation encodings and the pad value each operation uses outside the image.
`timescale 1ns/1ps
package bit_morph_3x3_pkg;

  localparam int PIPE_LATENCY = 3;

  typedef enum logic {
    MODE_ERODE  = 1'b0,
    MODE_DILATE = 1'b1
  } morph_mode_e;

  // Erosion pads with white so the border does not eat the image; dilation
  // pads with black so the border does not grow into it.
  localparam logic PAD_ERODE  = 1'b1;
  localparam logic PAD_DILATE = 1'b0;

  function automatic logic padFor(input morph_mode_e m);
    return (m == MODE_DILATE) ? PAD_DILATE : PAD_ERODE;
  endfunction

endpackage

// File: rtl/bit_morph_3x3_line_buffer.sv
// Two 1-bit line buffers packed into one 2-bit wide memory indexed by column.
// Bit 0 holds the previous line, bit 1 the line before it. Each access reads
// the old entry and pushes the new pixel in, shifting bit 0 into bit 1.
`timescale 1ns/1ps
module bit_line_buffer #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic          pix_i,
  output logic [1:0]    rdData_o
);

  logic [1:0] mem [DEPTH];

  // Read-before-write access: the old column contents go out, the new pixel goes in.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdData_o <= mem[addr_i];
      if (we_i) begin
        mem[addr_i] <= {mem[addr_i][0], pix_i};
      end
    end
  end

endmodule

// File: rtl/bit_morph_3x3.sv
// 3x3 binary erosion/dilation on a streamed image. Three registered stages:
// line-buffer read and pixel capture, window shift, and the AND/OR result.
`timescale 1ns/1ps
module bit_morph_3x3
  import bit_morph_3x3_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_frame_clken,
  input  logic per_img_bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_bit
);

  localparam int XW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int YW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_VDISP - 1);

  logic              hrefPrev_q, vsPrev_q;
  logic              accept, hrefRise, hrefFall, vsRise;
  logic [XW-1:0]     xCnt_q, xCnt_d, xCur;
  logic              lineFull_q, lineFull_d, fullCur;
  logic [YW-1:0]     yCnt_q, yCnt_d;
  morph_mode_e       mode_q, mode_d;

  logic              acc1_q, rise1_q, pix1_q, row1Ok_q, row2Ok_q;
  logic [1:0]        rdData;
  logic              acc2_q;
  logic [2:0][2:0]   win_q, win_d;
  logic              padBit;
  logic [2:0]        newCol;
  logic              bit_q;

  logic [PIPE_LATENCY-1:0] vsPipe_q, hrefPipe_q, clkenPipe_q;

  // Edge detection and the current column address; a line start forces column 0
  // in the same cycle so the first pixel of a line lands at x=0.
  always_comb begin
    accept   = per_frame_href & per_frame_clken;
    hrefRise = per_frame_href & ~hrefPrev_q;
    hrefFall = ~per_frame_href & hrefPrev_q;
    vsRise   = per_frame_vsync & ~vsPrev_q;
    xCur     = hrefRise ? '0 : xCnt_q;
    fullCur  = hrefRise ? 1'b0 : lineFull_q;
  end

  // Column, row and mode next-state: x saturates and flags a full line so
  // surplus pixels never overwrite the last buffer entry.
  always_comb begin
    xCnt_d     = xCnt_q;
    lineFull_d = lineFull_q;
    yCnt_d     = yCnt_q;
    mode_d     = mode_q;
    if (hrefRise) begin
      xCnt_d     = '0;
      lineFull_d = 1'b0;
    end
    if (accept) begin
      if (xCur == X_LAST) lineFull_d = 1'b1;
      else                xCnt_d     = xCur + XW'(1);
    end
    if (vsRise) begin
      yCnt_d = '0;
      mode_d = morph_mode_e'(mode);
    end else if (hrefFall && (yCnt_q != Y_LAST)) begin
      yCnt_d = yCnt_q + YW'(1);
    end
  end

  // Counter, edge-history and sampled-mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hrefPrev_q <= 1'b0;
      vsPrev_q   <= 1'b0;
      xCnt_q     <= '0;
      lineFull_q <= 1'b0;
      yCnt_q     <= '0;
      mode_q     <= MODE_ERODE;
    end else begin
      hrefPrev_q <= per_frame_href;
      vsPrev_q   <= per_frame_vsync;
      xCnt_q     <= xCnt_d;
      lineFull_q <= lineFull_d;
      yCnt_q     <= yCnt_d;
      mode_q     <= mode_d;
    end
  end

  bit_line_buffer #(
    .DEPTH (IMG_HDISP),
    .AW    (XW)
  ) u_lineBuf (
    .clk      (clk),
    .en_i     (accept),
    .we_i     (accept & ~fullCur),
    .addr_i   (xCur),
    .pix_i    (per_img_bit),
    .rdData_o (rdData)
  );

  // Capture stage: keeps the pixel and row validity aligned with the buffer read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1_q   <= 1'b0;
      rise1_q  <= 1'b0;
      pix1_q   <= 1'b0;
      row1Ok_q <= 1'b0;
      row2Ok_q <= 1'b0;
    end else begin
      acc1_q   <= accept;
      rise1_q  <= hrefRise;
      pix1_q   <= per_img_bit;
      row1Ok_q <= (yCnt_q != '0);
      row2Ok_q <= (yCnt_q > YW'(1));
    end
  end

  // Window next-state: reload with pad at line start, then shift in the new
  // column with rows above the image replaced by pad.
  always_comb begin
    padBit = padFor(mode_q);
    newCol = {row2Ok_q ? rdData[1] : padBit,
              row1Ok_q ? rdData[0] : padBit,
              pix1_q};
    win_d  = win_q;
    if (rise1_q) win_d = {3{{3{padBit}}}};
    if (acc1_q)  win_d = {newCol, win_d[2], win_d[1]};
  end

  // Window register and the accept flag travelling with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= {3{{3{PAD_ERODE}}}};
      acc2_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      acc2_q <= acc1_q;
    end
  end

  // Result register: only updated for real pixels, holds its value in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else if (acc2_q) begin
      bit_q <= (mode_q == MODE_DILATE) ? (|win_q) : (&win_q);
    end
  end

  // Sync signals delayed by the same depth as the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsPipe_q    <= '0;
      hrefPipe_q  <= '0;
      clkenPipe_q <= '0;
    end else begin
      vsPipe_q    <= {vsPipe_q[PIPE_LATENCY-2:0], per_frame_vsync};
      hrefPipe_q  <= {hrefPipe_q[PIPE_LATENCY-2:0], per_frame_href};
      clkenPipe_q <= {clkenPipe_q[PIPE_LATENCY-2:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vsPipe_q[PIPE_LATENCY-1];
  assign post_frame_href  = hrefPipe_q[PIPE_LATENCY-1];
  assign post_frame_clken = clkenPipe_q[PIPE_LATENCY-1];
  assign post_img_bit     = bit_q;

endmodule

// File: tb/tb_bit_morph_3x3.sv
// Scoreboard bench for bit_morph_3x3 on an 8x6 image: directed frames push
// hand-derived expected pixels, an independent monitor pops and compares.
`timescale 1ns/1ps
module tb_bit_morph_3x3;

  localparam int H = 8;
  localparam int V = 6;

  localparam int SC_ONES   = 0;
  localparam int SC_HOLE   = 1;
  localparam int SC_DOT    = 2;
  localparam int SC_CORNER = 3;
  localparam int SC_FAR    = 4;
  localparam int SC_ZEROS  = 5;

  typedef struct {
    int   x;
    int   y;
    logic b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic vs = 1'b0, hr = 1'b0, ck = 1'b0, pbit = 1'b0;
  logic postVs, postHr, postCk, postBit;

  int   checks = 0;
  int   failures = 0;
  int   outCnt = 0;
  exp_t expQ[$];
  logic [2:0] h0 = '0, h1 = '0, h2 = '0;

  always #5 clk = ~clk;

  bit_morph_3x3 #(
    .IMG_HDISP (H),
    .IMG_VDISP (V)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mode             (mode),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ck),
    .per_img_bit      (pbit),
    .post_frame_vsync (postVs),
    .post_frame_href  (postHr),
    .post_frame_clken (postCk),
    .post_img_bit     (postBit)
  );

  // Input image of each directed scenario.
  function automatic logic imgBit(input int sc, input int x, input int y);
    case (sc)
      SC_ONES:   return 1'b1;
      SC_HOLE:   return !(x == 3 && y == 2);
      SC_DOT:    return (x == 3 && y == 2);
      SC_CORNER: return (x == 0 && y == 0);
      SC_FAR:    return (x == 7 && y == 5);
      default:   return 1'b0;
    endcase
  endfunction

  // Hand-derived result: a feature at (a,b) affects outputs x=a..a+2, y=b..b+2.
  function automatic logic expBit(input int sc, input int x, input int y);
    case (sc)
      SC_ONES:   return 1'b1;
      SC_HOLE:   return !(x >= 3 && x <= 5 && y >= 2 && y <= 4);
      SC_DOT:    return (x >= 3 && x <= 5 && y >= 2 && y <= 4);
      SC_CORNER: return (x <= 2 && y <= 2);
      SC_FAR:    return (x == 7 && y == 5);
      default:   return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int x, input int y,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at (%0d,%0d): actual=%0h required=%0h", name, x, y, act, req);
    end
  endtask

  task automatic driveCycle(input logic v, input logic h, input logic c, input logic b);
    @(negedge clk);
    vs = v; hr = h; ck = c; pbit = b;
  endtask

  // One frame: sync, lines with clken toggling (or every clk when dense);
  // abortLine>=0 returns right after pixel x=3 of that line.
  task automatic applyStimulus(input int sc, input logic md, input bit dense, input int abortLine);
    outCnt = 0;
    repeat (4) driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
    mode = md;
    driveCycle(1'b1, 1'b0, 1'b0, 1'b0);
    driveCycle(1'b1, 1'b0, 1'b0, 1'b0);
    mode = ~md;
    driveCycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        driveCycle(1'b1, 1'b1, 1'b1, imgBit(sc, x, y));
        expQ.push_back('{x: x, y: y, b: expBit(sc, x, y)});
        if (abortLine == y && x == 3) return;
        if (!dense) driveCycle(1'b1, 1'b1, 1'b0, 1'b0);
      end
      repeat (4) driveCycle(1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (4) driveCycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Input history sampled at the DUT's edges for the latency comparison.
  always @(posedge clk) begin
    if (!rst_n) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
    end else begin
      h0 <= {vs, hr, ck};
      h1 <= h0;
      h2 <= h1;
    end
  end

  // Monitor: compares sync latency every cycle and pops the scoreboard per output pixel.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("syncLatency", -1, -1, {29'd0, postVs, postHr, postCk}, {29'd0, h2});
      if (postHr && postCk) begin
        outCnt++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPixel", -1, -1, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("pixel", e.x, e.y, {31'd0, postBit}, {31'd0, e.b});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("resetPostVs",  -1, -1, {31'd0, postVs},  32'd0);
    checkOutput("resetPostHr",  -1, -1, {31'd0, postHr},  32'd0);
    checkOutput("resetPostCk",  -1, -1, {31'd0, postCk},  32'd0);
    checkOutput("resetPostBit", -1, -1, {31'd0, postBit}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(SC_ONES, 1'b0, 1'b0, -1);
    checkOutput("countOnes", -1, -1, outCnt, 48);
    applyStimulus(SC_HOLE, 1'b0, 1'b0, -1);
    checkOutput("countHole", -1, -1, outCnt, 48);
    applyStimulus(SC_DOT, 1'b1, 1'b0, -1);
    checkOutput("countDot", -1, -1, outCnt, 48);
    applyStimulus(SC_CORNER, 1'b1, 1'b0, -1);
    applyStimulus(SC_FAR, 1'b1, 1'b0, -1);
    applyStimulus(SC_HOLE, 1'b0, 1'b1, -1);
    checkOutput("countDense", -1, -1, outCnt, 48);
    applyStimulus(SC_ZEROS, 1'b0, 1'b0, -1);
    applyStimulus(SC_ONES, 1'b0, 1'b0, -1);
    checkOutput("countAfterZeros", -1, -1, outCnt, 48);

    // Reset in the middle of a line while outputs are active.
    applyStimulus(SC_HOLE, 1'b1, 1'b0, 2);
    driveCycle(1'b1, 1'b1, 1'b0, 1'b0);
    driveCycle(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("preResetHref", -1, -1, {31'd0, postHr}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetPostVs",  -1, -1, {31'd0, postVs},  32'd0);
    checkOutput("midResetPostHr",  -1, -1, {31'd0, postHr},  32'd0);
    checkOutput("midResetPostCk",  -1, -1, {31'd0, postCk},  32'd0);
    checkOutput("midResetPostBit", -1, -1, {31'd0, postBit}, 32'd0);
    expQ.delete();
    repeat (3) driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(SC_HOLE, 1'b0, 1'b0, -1);
    checkOutput("countAfterReset", -1, -1, outCnt, 48);

    repeat (10) driveCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("queueEmpty", -1, -1, expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
